prefix_adder_pipe: RTL and testbench

Parametrised, pipelined parallel-prefix (Kogge-Stone) adder/subtractor for the fused multiply-add datapath. It replaces hand-instanced group carry-propagate cells with a generated prefix tree of any power-of-two width. Register ranks are inserted every `LVL_PER_STG` prefix levels. A valid/ready handshake on both sides supports backpressure and bubble collapsing. It sits after the partial-product reduction tree and feeds normalisation.

---
 rtl/fma_pkg.sv | 38 +++
 rtl/prefix_gp_cell.sv | 18 +
 rtl/prefix_adder_pipe.sv | 183 ++++++++++++++++++
 tb/tb_prefix_adder_pipe.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fma_pkg.sv
// Shared definitions for the fused multiply-add datapath.
//   clog2()      : ceiling log2, usable in constant expressions
//   num_stages() : register ranks needed after the input rank for a given
//                  operand width and number of prefix levels per rank
//   gp_t         : one (generate, propagate) pair; vectors are gp_t [W-1:0]
package fma_pkg;

    localparam int MIN_WIDTH       = 4;
    localparam int MAX_WIDTH       = 128;
    localparam int DEF_WIDTH       = 32;
    localparam int DEF_LVL_PER_STG = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic int num_stages(input int width, input int lvl_per_stg);
        int lvls;
        lvls = clog2(width);
        return (lvls + lvl_per_stg - 1) / lvl_per_stg;
    endfunction

    localparam int DEF_LEVELS = clog2(DEF_WIDTH);
    localparam int DEF_NSTG   = num_stages(DEF_WIDTH, DEF_LVL_PER_STG);

    typedef struct packed {
        logic g;
        logic p;
    } gp_t;

endpackage

// File: rtl/prefix_gp_cell.sv
// Kogge-Stone black cell: merges a higher-order (G, P) group with the
// adjacent lower-order group.
//   g_hi, p_hi : group terms of the more significant span
//   g_lo, p_lo : group terms of the less significant span
//   G, P       : combined group terms
module prefix_gp_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic G,
    output logic P
);

    assign G = g_hi | (p_hi & g_lo);
    assign P = p_hi & p_lo;

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready on both sides.
// Rank 0 registers the operands; a further register rank follows every
// LVL_PER_STG prefix levels, and the last rank holds the result.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid / in_ready   : operand handshake
//   a, b, cin, sub        : operands; sub=1 computes a - b (cin ignored)
//   out_valid / out_ready : result handshake
//   sum, cout, ovf        : result, carry out of MSB, signed overflow
module prefix_adder_pipe
    import fma_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int LVL_PER_STG = DEF_LVL_PER_STG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int L    = clog2(WIDTH);
    localparam int NSTG = num_stages(WIDTH, LVL_PER_STG);
    // intermediate ranks 1..NSTG-1; sized to at least one to stay legal
    localparam int NMID = (NSTG > 1) ? NSTG - 1 : 1;

    logic [NSTG:0] r_vld;
    logic [NSTG:0] w_rdy;

    // ready_k = !valid_k || ready_{k+1} unrolled to the end of the pipe,
    // which keeps each bit a flat AND/OR instead of a chained vector
    for (genvar k = 0; k <= NSTG; k++) begin : g_rdy
        assign w_rdy[k] = out_ready || !(&r_vld[NSTG:k]);
    end

    assign in_ready  = w_rdy[0] && !rst;
    assign out_valid = r_vld[NSTG];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
        end else begin
            if (w_rdy[0]) begin
                r_vld[0] <= in_valid;
            end
            for (int k = 1; k <= NSTG; k++) begin
                if (w_rdy[k]) begin
                    r_vld[k] <= r_vld[k-1];
                end
            end
        end
    end

    // ---------------- rank 0: operands ----------------
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_ci;

    always_ff @(posedge clk) begin
        if (w_rdy[0] && in_valid) begin
            r_a  <= a;
            r_b  <= b ^ {WIDTH{sub}};
            r_ci <= sub | cin;
        end
    end

    // Bit-level generate/propagate. The carry-in is absorbed into g_0 so
    // that every group G[i:0] is directly the carry out of bit i.
    gp_t [WIDTH-1:0] w_gp0;

    always_comb begin
        w_gp0 = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_gp0[i].g = r_a[i] & r_b[i];
            w_gp0[i].p = r_a[i] ^ r_b[i];
        end
        w_gp0[0].g = (r_a[0] & r_b[0]) | ((r_a[0] ^ r_b[0]) & r_ci);
    end

    // ---------------- prefix tree ----------------
    gp_t  [L-1:0][WIDTH-1:0]    w_lvl_in;
    gp_t  [L-1:0][WIDTH-1:0]    w_lvl_out;
    gp_t  [NMID-1:0][WIDTH-1:0] r_gp;
    logic [NMID-1:0][WIDTH-1:0] r_pb;
    logic [NMID-1:0]            r_pci;

    for (genvar k = 0; k < L; k++) begin : g_lvl
        localparam int STG  = k / LVL_PER_STG;
        localparam int DIST = 1 << k;

        // the first level of each rank starts from that rank's register
        if (k == 0) begin : g_src_in
            assign w_lvl_in[k] = w_gp0;
        end else if ((k % LVL_PER_STG) == 0) begin : g_src_reg
            assign w_lvl_in[k] = r_gp[STG-1];
        end else begin : g_src_lvl
            assign w_lvl_in[k] = w_lvl_out[k-1];
        end

        for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if (i >= DIST) begin : g_cell
                prefix_gp_cell u_cell (
                    .g_hi (w_lvl_in[k][i].g),
                    .p_hi (w_lvl_in[k][i].p),
                    .g_lo (w_lvl_in[k][i-DIST].g),
                    .p_lo (w_lvl_in[k][i-DIST].p),
                    .G    (w_lvl_out[k][i].g),
                    .P    (w_lvl_out[k][i].p)
                );
            end else begin : g_pass
                assign w_lvl_out[k][i] = w_lvl_in[k][i];
            end
        end
    end

    // Bit propagate vector and carry-in travelling alongside the tree,
    // indexed by the rank that feeds each stage.
    logic [NSTG-1:0][WIDTH-1:0] w_stg_pb;
    logic [NSTG-1:0]            w_stg_ci;

    always_comb begin
        w_stg_pb    = '0;
        w_stg_ci    = '0;
        w_stg_pb[0] = r_a ^ r_b;
        w_stg_ci[0] = r_ci;
        for (int s = 1; s < NSTG; s++) begin
            w_stg_pb[s] = r_pb[s-1];
            w_stg_ci[s] = r_pci[s-1];
        end
    end

    // ---------------- intermediate ranks 1..NSTG-1 ----------------
    always_ff @(posedge clk) begin
        for (int s = 1; s < NSTG; s++) begin
            if (w_rdy[s] && r_vld[s-1]) begin
                r_gp[s-1]  <= w_lvl_out[s*LVL_PER_STG-1];
                r_pb[s-1]  <= w_stg_pb[s-1];
                r_pci[s-1] <= w_stg_ci[s-1];
            end
        end
    end

    // ---------------- final XOR and output rank ----------------
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_sum_nxt;

    always_comb begin
        w_carry = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_carry[i] = w_lvl_out[L-1][i].g;
        end
        w_sum_nxt = w_stg_pb[NSTG-1] ^ {w_carry[WIDTH-2:0], w_stg_ci[NSTG-1]};
    end

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else if (w_rdy[NSTG] && r_vld[NSTG-1]) begin
            r_sum  <= w_sum_nxt;
            r_cout <= w_carry[WIDTH-1];
            r_ovf  <= w_carry[WIDTH-2] ^ w_carry[WIDTH-1];
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Self-checking bench for prefix_adder_pipe at WIDTH=32, LVL_PER_STG=2.
module tb_prefix_adder_pipe;

    localparam int W       = 32;
    localparam int LAT_EXP = 4;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;

    prefix_adder_pipe #(.WIDTH(W), .LVL_PER_STG(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[12];
    logic [33:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // behavioural 33-bit reference, returns {cout, ovf, sum}
    function automatic logic [33:0] ref_add(input logic [31:0] ra, input logic [31:0] rb,
                                            input logic rci, input logic rsb);
        logic [31:0] be;
        logic        ce;
        logic [32:0] t;
        logic        v;
        be = rsb ? ~rb : rb;
        ce = rsb ? 1'b1 : rci;
        t  = {1'b0, ra} + {1'b0, be} + {32'd0, ce};
        v  = (ra[31] == be[31]) && (t[31] != ra[31]);
        return {t[32], v, t[31:0]};
    endfunction

    task automatic send_one(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        a = v.a; b = v.b; cin = v.cin; sub = v.sub;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check($sformatf("vec%0d_in_ready", idx), {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            #1;
        end
        check($sformatf("vec%0d_latency", idx), 64'(lat), 64'(LAT_EXP));
        check($sformatf("vec%0d_sum", idx), {32'd0, sum}, {32'd0, v.sum});
        check($sformatf("vec%0d_cout", idx), {63'd0, cout}, {63'd0, v.cout});
        check($sformatf("vec%0d_ovf", idx), {63'd0, ovf}, {63'd0, v.ovf});
    endtask

    // mode 0: in_valid alternates 1/0; mode 1: random in_valid
    task automatic run_stream(input string name, input int nbeats, input int mode);
        int sent;
        int cyc;
        logic [33:0] e;
        sent = 0;
        cyc  = 0;
        exp_q.delete();
        while ((sent < nbeats || exp_q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            if (sent < nbeats) begin
                in_valid = (mode == 0) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
                a   = $urandom;
                b   = $urandom;
                cin = 1'($urandom_range(0, 1));
                sub = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check({name, "_unexpected_beat"}, {30'd0, cout, ovf, sum}, 64'h3_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    check(name, {30'd0, cout, ovf, sum}, {30'd0, e});
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add(a, b, cin, sub));
                sent++;
            end
            cyc++;
        end
        check({name, "_beats_sent"}, 64'(sent), 64'(nbeats));
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int acc;

        vecs[0]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[1]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[2]  = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4]  = '{32'h12345678, 32'h87654321, 1'b1, 1'b0, 32'h9999999A, 1'b0, 1'b0};
        vecs[5]  = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
        vecs[6]  = '{32'h00000005, 32'h00000005, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        vecs[7]  = '{32'h00000003, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0};
        vecs[8]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[9]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[10] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[11] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h80000000, 1'b0, 1'b1};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check("in_ready_during_rst", {63'd0, in_ready}, 64'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_outputs", {31'd0, cout, ovf, sum}, 64'd0);

        // directed table
        for (int i = 0; i < 12; i++) begin
            send_one(vecs[i], i);
        end

        // backpressure: out_ready low for 10 cycles
        @(negedge clk);
        acc = 0;
        out_ready = 1'b0; b = 32'h100; cin = 1'b0; sub = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clk);
            in_valid = 1'b1;
            a = 32'h10 + 32'(acc);
            #1;
            if (out_valid) begin
                check("bp_stable_sum", {32'd0, sum}, 64'h110);
            end
            if (in_ready) acc++;
            @(posedge clk);
        end
        @(negedge clk);
        #1;
        check("bp_accepted", 64'(acc), 64'd4);
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        check("bp_out_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("bp_drain%0d_valid", j), {63'd0, out_valid}, 64'd1);
            check($sformatf("bp_drain%0d_sum", j), {32'd0, sum}, 64'h110 + 64'(j));
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        check("bp_empty_after", {63'd0, out_valid}, 64'd0);

        // bubbles and random traffic
        run_stream("bubble", 200, 0);
        run_stream("random", 3000, 1);

        // reset with three beats in flight
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        a = 32'h1234; b = 32'h1; cin = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_in_ready_low", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        #1;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_outputs", {31'd0, cout, ovf, sum}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            if (out_valid) acc++;
        end
        check("midrst_no_stale", 64'(acc), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
